// File: rtl/physical_iob_delay_stepper_pkg.sv
// ============================================================================
// Module  : physical_iob_delay_stepper_pkg
// Brief   : Tap width and stepper state encoding shared by the IDELAY stepper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package physical_iob_delay_stepper_pkg;

   localparam int IDELAY_TAB_WIDTH = 5;

   typedef logic [IDELAY_TAB_WIDTH-1:0] tap_t;

   localparam logic [2:0] DLY_ST_INIT   = 3'd0;
   localparam logic [2:0] DLY_ST_IDLE   = 3'd1;
   localparam logic [2:0] DLY_ST_STEP   = 3'd2;
   localparam logic [2:0] DLY_ST_LOAD   = 3'd3;
   localparam logic [2:0] DLY_ST_SETTLE = 3'd4;
   localparam logic [2:0] DLY_ST_CHECK  = 3'd5;

endpackage

`default_nettype wire

// File: rtl/physical_iob_delay_stepper.sv
// ============================================================================
// Module  : physical_iob_delay_stepper
// Brief   : Converts a requested tap value into glitch-safe IDELAYE2 LD/CE/INC
//           control with settle time and CNTVALUEOUT readback checking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module physical_iob_delay_stepper
   import physical_iob_delay_stepper_pkg::*;
#(
   parameter logic [IDELAY_TAB_WIDTH-1:0] INIT_TABS     = 5'd0,
   parameter int                          SETTLE_CYCLES = 8,
   parameter bit                          CHECK_EN      = 1'b1
) (
   input  logic                        i_clk_200,
   input  logic                        local_clk_200_rst,
   input  logic [IDELAY_TAB_WIDTH-1:0] i_target_tabs,
   input  logic                        i_load,
   input  logic                        i_hold,
   input  logic [IDELAY_TAB_WIDTH-1:0] i_idelay_cntvalueout,
   output logic                        o_idelay_ld,
   output logic                        o_idelay_ce,
   output logic                        o_idelay_inc,
   output logic [IDELAY_TAB_WIDTH-1:0] o_idelay_cntvalue,
   output logic [IDELAY_TAB_WIDTH-1:0] o_cur_tabs,
   output logic                        o_busy,
   output logic                        o_step_done,
   output logic                        o_err
);

   localparam logic [7:0] c_settle_load = 8'(SETTLE_CYCLES - 1);

   logic [2:0] r_state;
   logic [2:0] w_state_nxt;
   logic [7:0] r_settle_cnt;
   logic [7:0] w_settle_nxt;
   logic       r_pending_load;
   logic       w_pending_nxt;
   logic       r_step_up;
   logic       w_step_up_nxt;
   tap_t       r_cur_tabs;
   tap_t       w_cur_nxt;
   tap_t       r_cntvalue;
   tap_t       w_cntvalue_nxt;
   logic       r_ld;
   logic       w_ld_nxt;
   logic       r_ce;
   logic       w_ce_nxt;
   logic       r_inc;
   logic       w_inc_nxt;
   logic       r_busy;
   logic       r_step_done;
   logic       w_step_done_nxt;
   logic       r_err;
   logic       w_err_nxt;
   logic       w_load_req;
   logic       w_mismatch;

   assign w_load_req = r_pending_load | i_load;
   assign w_mismatch = CHECK_EN && (r_state == DLY_ST_CHECK) &&
                       (i_idelay_cntvalueout != r_cur_tabs);

   // State register together with the registered datapath and outputs
   always_ff @(posedge i_clk_200 or negedge local_clk_200_rst) begin
      if (!local_clk_200_rst) begin
         r_state        <= DLY_ST_INIT;
         r_settle_cnt   <= 8'd0;
         r_pending_load <= 1'b0;
         r_step_up      <= 1'b0;
         r_cur_tabs     <= INIT_TABS;
         r_cntvalue     <= INIT_TABS;
         r_ld           <= 1'b0;
         r_ce           <= 1'b0;
         r_inc          <= 1'b0;
         r_busy         <= 1'b1;
         r_step_done    <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_settle_cnt   <= w_settle_nxt;
         r_pending_load <= w_pending_nxt;
         r_step_up      <= w_step_up_nxt;
         r_cur_tabs     <= w_cur_nxt;
         r_cntvalue     <= w_cntvalue_nxt;
         r_ld           <= w_ld_nxt;
         r_ce           <= w_ce_nxt;
         r_inc          <= w_inc_nxt;
         r_busy         <= (w_state_nxt != DLY_ST_IDLE);
         r_step_done    <= w_step_done_nxt;
         r_err          <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         DLY_ST_INIT:   w_state_nxt = DLY_ST_SETTLE;
         DLY_ST_IDLE: begin
            if (w_load_req)
               w_state_nxt = DLY_ST_LOAD;
            else if (!i_hold && (i_target_tabs != r_cur_tabs))
               w_state_nxt = DLY_ST_STEP;
         end
         DLY_ST_STEP:   w_state_nxt = DLY_ST_SETTLE;
         DLY_ST_LOAD:   w_state_nxt = DLY_ST_SETTLE;
         DLY_ST_SETTLE: if (r_settle_cnt == 8'd0) w_state_nxt = DLY_ST_CHECK;
         DLY_ST_CHECK:  w_state_nxt = w_mismatch ? DLY_ST_LOAD : DLY_ST_IDLE;
         default:       w_state_nxt = DLY_ST_INIT;
      endcase
   end

   always_comb begin
      w_settle_nxt    = r_settle_cnt;
      w_pending_nxt   = r_pending_load;
      w_step_up_nxt   = r_step_up;
      w_cur_nxt       = r_cur_tabs;
      w_cntvalue_nxt  = r_cntvalue;
      w_ld_nxt        = 1'b0;
      w_ce_nxt        = 1'b0;
      w_inc_nxt       = 1'b0;
      w_step_done_nxt = 1'b0;
      w_err_nxt       = r_err;

      if (r_state != DLY_ST_IDLE && i_load)
         w_pending_nxt = 1'b1;

      // Counter is reloaded whenever SETTLE is freshly entered, so every LD/CE
      // gets the full settle window.
      if (w_state_nxt == DLY_ST_SETTLE && r_state != DLY_ST_SETTLE)
         w_settle_nxt = c_settle_load;
      else if (r_state == DLY_ST_SETTLE && r_settle_cnt != 8'd0)
         w_settle_nxt = r_settle_cnt - 8'd1;

      case (r_state)
         DLY_ST_INIT: begin
            w_ld_nxt       = 1'b1;
            w_cntvalue_nxt = INIT_TABS;
         end
         DLY_ST_IDLE: begin
            if (w_load_req) begin
               w_cntvalue_nxt = i_target_tabs;
               w_cur_nxt      = i_target_tabs;
               w_pending_nxt  = 1'b0;
            end else begin
               w_step_up_nxt  = (i_target_tabs > r_cur_tabs);
            end
         end
         DLY_ST_STEP: begin
            // Direction was latched toward an in-range target, so no wrap occurs
            w_ce_nxt  = 1'b1;
            w_inc_nxt = r_step_up;
            w_cur_nxt = r_step_up ? r_cur_tabs + 5'd1 : r_cur_tabs - 5'd1;
         end
         DLY_ST_LOAD: w_ld_nxt = 1'b1;
         DLY_ST_CHECK: begin
            if (w_mismatch) begin
               w_err_nxt      = 1'b1;
               w_cntvalue_nxt = r_cur_tabs;
            end else begin
               w_step_done_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign o_idelay_ld       = r_ld;
   assign o_idelay_ce       = r_ce;
   assign o_idelay_inc      = r_inc;
   assign o_idelay_cntvalue = r_cntvalue;
   assign o_cur_tabs        = r_cur_tabs;
   assign o_busy            = r_busy;
   assign o_step_done       = r_step_done;
   assign o_err             = r_err;

endmodule

`default_nettype wire

// File: tb/tb_physical_iob_delay_stepper.sv
// ============================================================================
// Module  : tb_physical_iob_delay_stepper
// Brief   : Scoreboard bench for the IDELAY stepper with an IDELAYE2 echo model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_physical_iob_delay_stepper;

   localparam logic [4:0] C_INIT   = 5'd4;
   localparam int         C_SETTLE = 4;

   localparam logic [1:0] K_LD = 2'd0, K_CEI = 2'd1, K_CED = 2'd2, K_DONE = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [4:0] val;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] target = C_INIT;
   logic       load = 1'b0;
   logic       hold = 1'b0;
   logic [4:0] cntvalueout;
   logic       ld, ce, inc, busy, done, err;
   logic [4:0] cntvalue, cur;

   ev_t        q[$];
   int         checks = 0;
   int         failures = 0;
   logic [4:0] m_cur = C_INIT;
   logic       m_err = 1'b0;
   logic [4:0] m_dly = 5'd0;
   logic       corrupt = 1'b0;
   logic       arm_fault = 1'b0;
   int         cyc = 0;
   int         last_ce_cyc = 0;
   logic       last_was_ce = 1'b0;

   always #5 clk = ~clk;

   physical_iob_delay_stepper #(
      .INIT_TABS    (C_INIT),
      .SETTLE_CYCLES(C_SETTLE),
      .CHECK_EN     (1'b1)
   ) dut (
      .i_clk_200           (clk),
      .local_clk_200_rst   (rst_n),
      .i_target_tabs       (target),
      .i_load              (load),
      .i_hold              (hold),
      .i_idelay_cntvalueout(cntvalueout),
      .o_idelay_ld         (ld),
      .o_idelay_ce         (ce),
      .o_idelay_inc        (inc),
      .o_idelay_cntvalue   (cntvalue),
      .o_cur_tabs          (cur),
      .o_busy              (busy),
      .o_step_done         (done),
      .o_err               (err)
   );

   // IDELAYE2 behaviour: LD loads CNTVALUEIN, CE moves one tap; optional one-shot corruption
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ld) m_dly <= cntvalue;
      else if (ce) m_dly <= inc ? m_dly + 5'd1 : m_dly - 5'd1;
      if (ld) corrupt <= 1'b0;
      else if (ce && arm_fault) corrupt <= 1'b1;
   end
   assign cntvalueout = m_dly + {4'd0, corrupt};

   function automatic ev_t mk(input logic [1:0] k, input logic [4:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      return e;
   endfunction

   task automatic check_event(input logic [1:0] k, input logic [4:0] a);
      ev_t e;
      checks++;
      if (q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event kind=%0d val=%0d (queue empty)", k, a);
      end else begin
         e = q.pop_front();
         if (e.kind != k || e.val != a) begin
            failures++;
            $display("FAIL event actual kind=%0d val=%0d required kind=%0d val=%0d",
                     k, a, e.kind, e.val);
         end
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an LD, CE or step_done
   always @(negedge clk) begin
      if (rst_n) begin
         if (ld || ce) begin
            checks++;
            if (ld && ce) begin
               failures++;
               $display("FAIL ld_ce_overlap actual ld=%0b ce=%0b required not both", ld, ce);
            end
         end
         if (ld) begin
            check_event(K_LD, cntvalue);
            last_was_ce = 1'b0;
         end
         if (ce) begin
            check_event(inc ? K_CEI : K_CED, cur);
            last_ce_cyc = cyc;
            last_was_ce = 1'b1;
         end
         if (done) begin
            check_event(K_DONE, cur);
            if (last_was_ce) begin
               checks++;
               if (cyc - last_ce_cyc != C_SETTLE + 1) begin
                  failures++;
                  $display("FAIL ce_to_done_gap actual=%0d required=%0d",
                           cyc - last_ce_cyc, C_SETTLE + 1);
               end
            end
            last_was_ce = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic check_reset_vals();
      expect_val("reset_outputs", {ld, ce, inc, cntvalue, cur, busy, done, err},
                 {1'b0, 1'b0, 1'b0, C_INIT, C_INIT, 1'b1, 1'b0, 1'b0});
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout actual queue=%0d busy=%0b required queue=0 busy=0",
                  q.size(), busy);
         q.delete();
      end
      expect_val("cur_tabs", cur, m_cur);
      expect_val("err_flag", err, m_err);
   endtask

   task automatic wait_ce();
      bit seen = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (ce) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL ce_timeout actual=none required=ce pulse");
      end
   endtask

   // Reference: one CE + one step_done per tap, moving one unit toward the target
   task automatic push_steps(input logic [4:0] t);
      while (m_cur != t) begin
         if (t > m_cur) begin
            m_cur = m_cur + 5'd1;
            q.push_back(mk(K_CEI, m_cur));
         end else begin
            m_cur = m_cur - 5'd1;
            q.push_back(mk(K_CED, m_cur));
         end
         q.push_back(mk(K_DONE, m_cur));
      end
   endtask

   task automatic do_step(input logic [4:0] t);
      tick();
      push_steps(t);
      target = t;
      wait_idle();
   endtask

   task automatic do_load(input logic [4:0] t);
      tick();
      q.push_back(mk(K_LD, t));
      q.push_back(mk(K_DONE, t));
      m_cur  = t;
      target = t;
      load   = 1'b1;
      tick();
      load = 1'b0;
      wait_idle();
   endtask

   task automatic start_one_step();
      logic [4:0] t1;
      t1 = (m_cur == 5'd31) ? 5'd30 : m_cur + 5'd1;
      tick();
      push_steps(t1);
      target = t1;
      wait_ce();
   endtask

   initial begin
      logic [4:0] t;

      // Reset, INIT load of C_INIT
      repeat (3) tick();
      check_reset_vals();
      q.push_back(mk(K_LD, C_INIT));
      q.push_back(mk(K_DONE, C_INIT));
      rst_n = 1'b1;
      tick();
      expect_val("init_ld_cycle1", {ld, cntvalue}, {1'b1, C_INIT});
      wait_idle();

      do_step(5'd7);

      // Load wins over a simultaneous target change
      do_load(5'd20);

      // Hold blocks stepping in IDLE
      tick();
      hold   = 1'b1;
      t      = m_cur ^ 5'd9;
      target = t;
      repeat (50) tick();
      expect_val("hold_busy", busy, 0);
      expect_val("hold_cur", cur, m_cur);
      push_steps(t);
      hold = 1'b0;
      tick();
      tick();
      expect_val("hold_release_busy", busy, 1);
      wait_idle();

      // Corrupted readback: err, resync LD, single done
      tick();
      t = (m_cur == 5'd31) ? 5'd30 : m_cur + 5'd1;
      arm_fault = 1'b1;
      q.push_back(mk((t > m_cur) ? K_CEI : K_CED, t));
      q.push_back(mk(K_LD, t));
      q.push_back(mk(K_DONE, t));
      m_cur  = t;
      m_err  = 1'b1;
      target = t;
      wait_idle();
      arm_fault = 1'b0;

      for (int i = 0; i < 10; i++) begin
         t = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) do_load(t);
         else do_step(t);
      end
      do_step(5'd0);
      do_step(5'd31);

      // Pending load latched during SETTLE, target read in IDLE
      do_step(5'd10);
      start_one_step();
      tick();
      tick();
      load = 1'b1;
      tick();
      load   = 1'b0;
      target = 5'd31;
      q.push_back(mk(K_LD, 5'd31));
      q.push_back(mk(K_DONE, 5'd31));
      m_cur = 5'd31;
      wait_idle();

      // Asynchronous reset in the middle of SETTLE
      do_step(5'd12);
      start_one_step();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      q.delete();
      m_cur  = C_INIT;
      m_err  = 1'b0;
      target = C_INIT;
      last_was_ce = 1'b0;
      q.push_back(mk(K_LD, C_INIT));
      q.push_back(mk(K_DONE, C_INIT));
      tick();
      tick();
      rst_n = 1'b1;
      wait_idle();

      for (int i = 0; i < 4; i++) begin
         t = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 2) == 0) do_load(t);
         else do_step(t);
      end

      repeat (5) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
